// File: rtl/arb_gray_slot7.sv
// ---------------------------------------------------------------------------
// arb_gray_slot7
//
// Round-robin time-slot arbiter sharing one datapath resource between seven
// requesters. The slot pointer walks a 3-bit mod-7 Gray sequence
// (000, 001, 011, 010, 110, 111, 101, then back to 000), the same sequence our
// JK-based Gray counters produce. One requester owns the resource at a time.
// It keeps it until it drops its request or until HOLD_MAX consecutive cycles
// have elapsed. The pointer then advances.
//
// Parameters
//   HOLD_MAX  maximum consecutive grant cycles per owner (1..255); 0 disables
//             the timeout.
//
// Ports
//   ck    in   1  clock, rising edge
//   clr   in   1  synchronous active-low reset, sampled on the rising edge of ck
//   req   in   7  request lines, req[i] belongs to slot i
//   gnt   out  7  one-hot grant, registered, all-zero when idle
//   slot  out  3  current Gray-coded slot pointer, registered
//   busy  out  1  high while any gnt bit is high, registered
//   tout  out  1  one-cycle pulse when a grant is revoked by timeout
//
// Build option
//   ARB_SKIP_EN  when defined, an idle arbiter searches all seven slots in
//                Gray order, starting at the current pointer. It grants the
//                first requester within one cycle. When undefined, the pointer
//                steps one slot per cycle while idle.
// ---------------------------------------------------------------------------
module arb_gray_slot7 #(
   parameter int HOLD_MAX = 15
) (
   input  logic       ck,
   input  logic       clr,
   input  logic [6:0] req,
   output logic [6:0] gnt,
   output logic [2:0] slot,
   output logic       busy,
   output logic       tout
);

   typedef enum logic [0:0] {
      ST_SCAN = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIM = HOLD_MAX[7:0];
   localparam logic       HOLD_EN  = (HOLD_MAX != 32'sd0);

   // Successor of a Gray slot code; the unused code 100 recovers to 000.
   function automatic logic [2:0] f_gray_next(input logic [2:0] code);
      logic [2:0] v_nxt;
      case (code)
         3'b000:  v_nxt = 3'b001;
         3'b001:  v_nxt = 3'b011;
         3'b011:  v_nxt = 3'b010;
         3'b010:  v_nxt = 3'b110;
         3'b110:  v_nxt = 3'b111;
         3'b111:  v_nxt = 3'b101;
         3'b101:  v_nxt = 3'b000;
         default: v_nxt = 3'b000;
      endcase
      return v_nxt;
   endfunction

   // Requester index owning a Gray slot code; 7 marks the illegal code 100.
   function automatic logic [2:0] f_gray_idx(input logic [2:0] code);
      logic [2:0] v_idx;
      case (code)
         3'b000:  v_idx = 3'd0;
         3'b001:  v_idx = 3'd1;
         3'b011:  v_idx = 3'd2;
         3'b010:  v_idx = 3'd3;
         3'b110:  v_idx = 3'd4;
         3'b111:  v_idx = 3'd5;
         3'b101:  v_idx = 3'd6;
         default: v_idx = 3'd7;
      endcase
      return v_idx;
   endfunction

   // Gray slot code for a requester index (inverse of f_gray_idx).
   function automatic logic [2:0] f_idx_gray(input logic [2:0] idx);
      logic [2:0] v_code;
      case (idx)
         3'd0:    v_code = 3'b000;
         3'd1:    v_code = 3'b001;
         3'd2:    v_code = 3'b011;
         3'd3:    v_code = 3'b010;
         3'd4:    v_code = 3'b110;
         3'd5:    v_code = 3'b111;
         3'd6:    v_code = 3'b101;
         default: v_code = 3'b000;
      endcase
      return v_code;
   endfunction

   // One-hot select for a requester index; index 7 yields no select at all.
   function automatic logic [6:0] f_onehot(input logic [2:0] idx);
      logic [6:0] v_sel;
      case (idx)
         3'd0:    v_sel = 7'b000_0001;
         3'd1:    v_sel = 7'b000_0010;
         3'd2:    v_sel = 7'b000_0100;
         3'd3:    v_sel = 7'b000_1000;
         3'd4:    v_sel = 7'b001_0000;
         3'd5:    v_sel = 7'b010_0000;
         3'd6:    v_sel = 7'b100_0000;
         default: v_sel = 7'b000_0000;
      endcase
      return v_sel;
   endfunction

`ifdef ARB_SKIP_EN
   // First requester at or after index 'start' in round-robin order.
   // The result is {hit, index}. The loop runs backwards, so the nearest
   // match is the one written last.
   function automatic logic [3:0] f_search(input logic [6:0] rq, input logic [2:0] start);
      logic [3:0] v_res;
      logic [3:0] v_pos;
      v_res = 4'b0000;
      for (int k = 6; k >= 0; k--) begin
         v_pos = {1'b0, start} + 4'(k);
         if (v_pos >= 4'd7) begin
            v_pos = v_pos - 4'd7;
         end else begin
            v_pos = v_pos;
         end
         if (rq[v_pos[2:0]]) begin
            v_res = {1'b1, v_pos[2:0]};
         end else begin
            v_res = v_res;
         end
      end
      return v_res;
   endfunction
`endif

   state_t     r_state;
   logic [2:0] r_slot;
   logic [6:0] r_gnt;
   logic       r_busy;
   logic       r_tout;
   logic [7:0] r_cnt;

   state_t     w_state_nxt;
   logic [2:0] w_slot_nxt;
   logic [6:0] w_gnt_nxt;
   logic       w_busy_nxt;
   logic       w_tout_nxt;
   logic [7:0] w_cnt_nxt;

   logic [2:0] w_idx;
   logic       w_legal;
   logic [6:0] w_sel;
   logic       w_req_cur;
   logic       w_at_lim;

   assign w_idx     = f_gray_idx(r_slot);
   assign w_legal   = (w_idx != 3'd7);
   assign w_sel     = f_onehot(w_idx);
   assign w_req_cur = |(req & w_sel);
   // With HOLD_MAX = 0 this never fires, so an owner may hold indefinitely.
   assign w_at_lim  = HOLD_EN && (r_cnt == HOLD_LIM);

`ifdef ARB_SKIP_EN
   logic [3:0] w_search;
   logic       w_hit;
   logic [2:0] w_hit_idx;

   assign w_search  = f_search(req, w_idx);
   assign w_hit     = w_search[3];
   assign w_hit_idx = w_search[2:0];
`endif

   // Next-state and next-output decode for the SCAN/OWN arbiter.
   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      w_gnt_nxt   = r_gnt;
      w_busy_nxt  = r_busy;
      w_tout_nxt  = 1'b0;
      w_cnt_nxt   = r_cnt;

      if (!w_legal) begin
         // Illegal pointer code: park on slot 0 with nothing granted.
         w_state_nxt = ST_SCAN;
         w_slot_nxt  = 3'b000;
         w_gnt_nxt   = 7'b000_0000;
         w_busy_nxt  = 1'b0;
         w_cnt_nxt   = 8'd0;
      end else begin
         case (r_state)
            ST_SCAN: begin
`ifdef ARB_SKIP_EN
               if (w_hit) begin
                  w_state_nxt = ST_OWN;
                  w_slot_nxt  = f_idx_gray(w_hit_idx);
                  w_gnt_nxt   = f_onehot(w_hit_idx);
                  w_busy_nxt  = 1'b1;
                  w_cnt_nxt   = 8'd1;
               end else begin
                  w_slot_nxt  = r_slot;
               end
`else
               if (w_req_cur) begin
                  w_state_nxt = ST_OWN;
                  w_gnt_nxt   = w_sel;
                  w_busy_nxt  = 1'b1;
                  w_cnt_nxt   = 8'd1;
               end else begin
                  w_slot_nxt  = f_gray_next(r_slot);
               end
`endif
            end
            ST_OWN: begin
               if (!w_req_cur) begin
                  // Release takes precedence over a coincident timeout.
                  w_state_nxt = ST_SCAN;
                  w_slot_nxt  = f_gray_next(r_slot);
                  w_gnt_nxt   = 7'b000_0000;
                  w_busy_nxt  = 1'b0;
               end else if (w_at_lim) begin
                  w_state_nxt = ST_SCAN;
                  w_slot_nxt  = f_gray_next(r_slot);
                  w_gnt_nxt   = 7'b000_0000;
                  w_busy_nxt  = 1'b0;
                  w_tout_nxt  = 1'b1;
               end else if (r_cnt != 8'hFF) begin
                  // Saturate so an unlimited hold never wraps the counter.
                  w_cnt_nxt   = r_cnt + 8'd1;
               end else begin
                  w_cnt_nxt   = r_cnt;
               end
            end
            default: begin
               w_state_nxt = ST_SCAN;
               w_slot_nxt  = 3'b000;
               w_gnt_nxt   = 7'b000_0000;
               w_busy_nxt  = 1'b0;
               w_cnt_nxt   = 8'd0;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low clear.
   always_ff @(posedge ck) begin
      if (!clr) begin
         r_state <= ST_SCAN;
         r_slot  <= 3'b000;
         r_gnt   <= 7'b000_0000;
         r_busy  <= 1'b0;
         r_tout  <= 1'b0;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
         r_gnt   <= w_gnt_nxt;
         r_busy  <= w_busy_nxt;
         r_tout  <= w_tout_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign gnt  = r_gnt;
   assign slot = r_slot;
   assign busy = r_busy;
   assign tout = r_tout;

endmodule

// File: tb/tb_arb_gray_slot7.sv
// Bench for arb_gray_slot7. Three instances with HOLD_MAX = 4, 0 and 2 share
// one request bus. A positional round-robin model predicts every output of
// every instance each cycle. Directed sequences cover the reset, Gray walk,
// release, timeout, coincident release/timeout and mid-grant reset cases.
module tb_arb_gray_slot7;

   localparam int HM0 = 4;
   localparam int HM1 = 0;
   localparam int HM2 = 2;

   logic           ck = 1'b0;
   logic           clr = 1'b0;
   logic [6:0]     req = 7'h00;
   logic [2:0][6:0] o_gnt;
   logic [2:0][2:0] o_slot;
   logic [2:0]      o_busy;
   logic [2:0]      o_tout;

   int n_total = 0;
   int n_bad   = 0;

   int   m_hold [3] = '{HM0, HM1, HM2};
   int   m_pos  [3] = '{0, 0, 0};
   int   m_own  [3] = '{-1, -1, -1};
   int   m_held [3] = '{0, 0, 0};
   bit   m_tout [3] = '{1'b0, 1'b0, 1'b0};
   logic [2:0] gray_tab [7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101};
   logic [2:0] walk     [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b000, 3'b001};

   arb_gray_slot7 #(.HOLD_MAX(HM0)) u_dut0 (
      .ck(ck), .clr(clr), .req(req),
      .gnt(o_gnt[0]), .slot(o_slot[0]), .busy(o_busy[0]), .tout(o_tout[0]));
   arb_gray_slot7 #(.HOLD_MAX(HM1)) u_dut1 (
      .ck(ck), .clr(clr), .req(req),
      .gnt(o_gnt[1]), .slot(o_slot[1]), .busy(o_busy[1]), .tout(o_tout[1]));
   arb_gray_slot7 #(.HOLD_MAX(HM2)) u_dut2 (
      .ck(ck), .clr(clr), .req(req),
      .gnt(o_gnt[2]), .slot(o_slot[2]), .busy(o_busy[2]), .tout(o_tout[2]));

   // Free-running clock, 10 time units per period.
   always #5 ck = ~ck;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock edge of the reference model for instance d. The pointer is a
   // plain position 0..6 and the owner is a requester number (-1 = none).
   task automatic model_step(input int d);
      m_tout[d] = 1'b0;
      if (!clr) begin
         m_pos[d]  = 0;
         m_own[d]  = -1;
         m_held[d] = 0;
      end else if (m_own[d] < 0) begin
`ifdef ARB_SKIP_EN
         for (int k = 0; k < 7; k++) begin
            int q = (m_pos[d] + k) % 7;
            if (m_own[d] < 0 && req[q]) begin
               m_own[d]  = q;
               m_pos[d]  = q;
               m_held[d] = 1;
            end
         end
`else
         if (req[m_pos[d]]) begin
            m_own[d]  = m_pos[d];
            m_held[d] = 1;
         end else begin
            m_pos[d] = (m_pos[d] + 1) % 7;
         end
`endif
      end else if (!req[m_own[d]]) begin
         m_own[d] = -1;
         m_pos[d] = (m_pos[d] + 1) % 7;
      end else if (m_hold[d] != 0 && m_held[d] == m_hold[d]) begin
         m_own[d]  = -1;
         m_tout[d] = 1'b1;
         m_pos[d]  = (m_pos[d] + 1) % 7;
      end else begin
         m_held[d]++;
      end
   endtask

   task automatic tick();
      @(posedge ck);
      for (int d = 0; d < 3; d++) model_step(d);
      #1;
      for (int d = 0; d < 3; d++) begin
         logic [6:0] eg;
         eg = (m_own[d] < 0) ? 7'h00 : (7'h01 << m_own[d]);
         check_val($sformatf("m%0d_gnt", d),  o_gnt[d],  eg);
         check_val($sformatf("m%0d_slot", d), o_slot[d], gray_tab[m_pos[d]]);
         check_val($sformatf("m%0d_busy", d), o_busy[d], (m_own[d] >= 0) ? 1'b1 : 1'b0);
         check_val($sformatf("m%0d_tout", d), o_tout[d], m_tout[d]);
      end
   endtask

   task automatic do_reset();
      clr = 1'b0;
      req = 7'h00;
      tick();
      clr = 1'b1;
   endtask

   initial begin
      // Reset held with every request high
      clr = 1'b0;
      req = 7'h7F;
      tick();
      tick();
      check_val("rst_gnt",  o_gnt[0],  7'h00);
      check_val("rst_slot", o_slot[0], 3'b000);
      check_val("rst_busy", o_busy[0], 1'b0);
      check_val("rst_tout", o_tout[0], 1'b0);
      clr = 1'b1;
      tick();
      check_val("rst_first_gnt",  o_gnt[0],  7'b000_0001);
      check_val("rst_first_slot", o_slot[0], 3'b000);

      // Idle walk of the pointer
      do_reset();
      check_val("walk0", o_slot[0], walk[0]);
      for (int i = 1; i < 9; i++) begin
         tick();
`ifdef ARB_SKIP_EN
         check_val($sformatf("walk%0d", i), o_slot[0], 3'b000);
`else
         check_val($sformatf("walk%0d", i), o_slot[0], walk[i]);
`endif
      end

      // Release and rotate: owner 0 keeps the grant 3 cycles, then slot 3 follows
      do_reset();
      req = 7'b000_1001;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("rel_own%0d", i), o_gnt[0], 7'b000_0001);
      end
      req = 7'b000_1000;
      tick();
      check_val("rel_drop", o_gnt[0], 7'h00);
`ifndef ARB_SKIP_EN
      for (int i = 0; i < 2; i++) begin
         tick();
         check_val($sformatf("rel_gap%0d", i), o_gnt[0], 7'h00);
      end
`endif
      tick();
      check_val("rel_g3",   o_gnt[0],  7'b000_1000);
      check_val("rel_slot", o_slot[0], 3'b010);

      // Timeout on the HOLD_MAX=4 instance; the HOLD_MAX=0 instance holds on
      do_reset();
      req = 7'b000_0100;
      for (int i = 0; i < 10 && !o_gnt[0][2]; i++) tick();
      check_val("to_granted", o_gnt[0], 7'b000_0100);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("to_hold%0d", i), o_gnt[0], 7'b000_0100);
      end
      tick();
      check_val("to_gnt_off", o_gnt[0],  7'h00);
      check_val("to_pulse",   o_tout[0], 1'b1);
      check_val("to_busy",    o_busy[0], 1'b0);
      check_val("nolim_hold", o_gnt[1],  7'b000_0100);
`ifndef ARB_SKIP_EN
      for (int i = 0; i < 6; i++) begin
         tick();
         check_val($sformatf("to_gap%0d", i),  o_gnt[0],  7'h00);
         check_val($sformatf("to_tout%0d", i), o_tout[0], 1'b0);
      end
`endif
      tick();
      check_val("to_regrant",  o_gnt[0],  7'b000_0100);
      check_val("to_reslot",   o_slot[0], 3'b011);
      for (int i = 0; i < 20; i++) begin
         tick();
         check_val("nolim_keep", o_gnt[1], 7'b000_0100);
      end

      // Release and timeout on the same edge (HOLD_MAX=2): release wins
      do_reset();
      req = 7'b000_0001;
      tick();
      check_val("sim_g1", o_gnt[2], 7'b000_0001);
      tick();
      check_val("sim_g2", o_gnt[2], 7'b000_0001);
      req = 7'h00;
      tick();
      check_val("sim_gnt",  o_gnt[2],  7'h00);
      check_val("sim_tout", o_tout[2], 1'b0);
      do_reset();
      req = 7'b000_0001;
      tick();
      tick();
      tick();
      check_val("lim2_gnt",  o_gnt[2],  7'h00);
      check_val("lim2_tout", o_tout[2], 1'b1);

      // Reset in the middle of a grant on slot 110
      do_reset();
      req = 7'b001_0000;
      for (int i = 0; i < 10 && !o_gnt[0][4]; i++) tick();
      check_val("mrst_own",  o_gnt[0],  7'b001_0000);
      check_val("mrst_slot", o_slot[0], 3'b110);
      clr = 1'b0;
      tick();
      check_val("mrst_gnt",   o_gnt[0],  7'h00);
      check_val("mrst_slot0", o_slot[0], 3'b000);
      check_val("mrst_busy",  o_busy[0], 1'b0);
      check_val("mrst_tout",  o_tout[0], 1'b0);
      tick();
      check_val("mrst_tout2", o_tout[0], 1'b0);
      clr = 1'b1;

      // Random traffic: request bits toggle occasionally, rare resets
      req = 7'h00;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 7; b++) begin
            if ($urandom_range(7) == 0) req[b] = ~req[b];
         end
         clr = ($urandom_range(99) != 0) ? 1'b1 : 1'b0;
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
